// File: rtl/uart_rx_fifo_if.sv
// Read-side port bundle of the UART receive FIFO: pop strobe, head data, valid and fill level.
`timescale 1ns / 1ps
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [CW-1:0]        count;

  modport master (output rd_en, input rd_data, input rd_valid, input count);
  modport slave  (input rd_en, output rd_data, output rd_valid, output count);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/framing/break/overrun
// detection and a show-ahead receive FIFO.
`timescale 1ns / 1ps
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  input  logic           err_clr,
  uart_rx_fifo_if.slave  rd,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overrun,
  output logic           break_det
);

  localparam int unsigned Div = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned PW  = $clog2(OVERSAMPLE);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] PhS0 = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PhS1 = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PhV  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PhEnd = PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StWaitIdle, StIdle, StStart, StData, StParity, StStop} state_e;

  logic                 rx_meta_q, rx_s;
  logic [DW-1:0]        div_q;
  logic                 tick;
  state_e               state_q;
  logic [PW-1:0]        phase_q, phase_nxt;
  logic [3:0]           bit_cnt_q;
  logic                 s0_q, s1_q, vote, vote_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_bit_q, par_bad_q, stop_low_q, stop_low_nxt;
  logic                 push_q, push_perr_q, push_ferr_q, push_brk_q;
  logic [DATA_BITS-1:0] push_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      div_q     <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
      div_q     <= tick ? '0 : div_q + DW'(1);
    end
  end

  assign tick         = (div_q == DW'(Div - 1));
  assign phase_nxt    = (phase_q == PhEnd) ? '0 : phase_q + PW'(1);
  assign vote         = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign stop_low_nxt = stop_low_q | ~vote;

  // Bit states: phase_q holds the tick index within the current bit (0 on the start-detect tick).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StWaitIdle;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      vote_q      <= 1'b1;
      sh_q        <= '0;
      par_bit_q   <= 1'b0;
      par_bad_q   <= 1'b0;
      stop_low_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_perr_q <= 1'b0;
      push_ferr_q <= 1'b0;
      push_brk_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (tick) begin
        if (state_q != StWaitIdle && state_q != StIdle) begin
          phase_q <= phase_nxt;
          if (phase_nxt == PhS0) s0_q <= rx_s;
          if (phase_nxt == PhS1) s1_q <= rx_s;
          if (phase_nxt == PhV) vote_q <= vote;
        end
        case (state_q)
          StWaitIdle: if (rx_s) state_q <= StIdle;
          StIdle: begin
            if (!rx_s) begin
              state_q    <= StStart;
              phase_q    <= '0;
              bit_cnt_q  <= '0;
              par_bit_q  <= 1'b0;
              par_bad_q  <= 1'b0;
              stop_low_q <= 1'b0;
            end
          end
          StStart: if (phase_nxt == PhEnd) state_q <= vote_q ? StIdle : StData;
          StData: begin
            if (phase_nxt == PhV) sh_q <= {vote, sh_q[DATA_BITS-1:1]};
            if (phase_nxt == PhEnd) begin
              if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY != 0) ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
          StParity: begin
            if (phase_nxt == PhV) begin
              par_bit_q <= vote;
              par_bad_q <= (^sh_q) ^ vote ^ (PARITY == 1);
            end
            if (phase_nxt == PhEnd) state_q <= StStop;
          end
          StStop: begin
            if (phase_nxt == PhV) begin
              stop_low_q <= stop_low_nxt;
              if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                // Push at the vote point of the last stop bit, errors travel with the word.
                push_q      <= 1'b1;
                push_data_q <= sh_q;
                push_perr_q <= par_bad_q;
                push_ferr_q <= stop_low_nxt;
                push_brk_q  <= stop_low_nxt & (sh_q == '0) & ~par_bit_q;
                bit_cnt_q   <= '0;
                state_q     <= vote ? StIdle : StWaitIdle;
              end
            end else if (phase_nxt == PhEnd) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          default: state_q <= StWaitIdle;
        endcase
      end
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, do_pop, do_push, ovr_event;
  logic                 parity_err_q, frame_err_q, overrun_q, break_det_q;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign do_pop    = rd.rd_en && (count_q != '0);
  assign do_push   = push_q && (!full || do_pop);
  assign ovr_event = push_q && full && !do_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new error event overrides a simultaneous clear.
      parity_err_q <= (push_q & push_perr_q) | (parity_err_q & ~err_clr);
      frame_err_q  <= (push_q & push_ferr_q) | (frame_err_q & ~err_clr);
      break_det_q  <= (push_q & push_brk_q) | (break_det_q & ~err_clr);
      overrun_q    <= ovr_event | (overrun_q & ~err_clr);
    end
  end

  assign rd.rd_data  = mem_q[rd_ptr_q];
  assign rd.rd_valid = (count_q != '0);
  assign rd.count    = count_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign break_det   = break_det_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8N1 instance and an even-parity instance, fast tick divider.
`timescale 1ns / 1ps
module tb_uart_rx_fifo;
  localparam int unsigned CF = 6400000;
  localparam int unsigned BD = 100000;
  localparam int BitNs = 640;  // 64 clocks of 10 ns: divider of 4, 16 ticks per bit

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic pe_a, fe_a, ov_a, bk_a, pe_b, fe_b, ov_b, bk_b;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rd_a ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) rd_b ();

  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .rx(rx_a), .err_clr(clr_a), .rd(rd_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .break_det(bk_a)
  );

  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_par (
    .clk(clk), .reset(reset), .rx(rx_b), .err_clr(clr_b), .rd(rd_b),
    .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .break_det(bk_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rd_a.rd_en && rd_a.rd_valid) begin
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL a_pop: popped 0x%0h, expected nothing", rd_a.rd_data);
      end else check("a_pop", rd_a.rd_data, exp_a.pop_front());
    end
    if (rd_b.rd_en && rd_b.rd_valid) begin
      if (exp_b.size() == 0) begin
        checks++;
        $display("FAIL b_pop: popped 0x%0h, expected nothing", rd_b.rd_data);
      end else check("b_pop", rd_b.rd_data, exp_b.pop_front());
    end
  end

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input int bit_ns);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      #(bit_ns);
    end
  endtask

  task automatic frame8(input bit sel, input logic [7:0] data, input logic stop,
                        input int bit_ns);
    send_bits(sel, {6'b0, stop, data, 1'b0}, 10, bit_ns);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input bit sel);
    @(posedge clk);
    #1;
    if (sel) rd_b.rd_en = 1'b1;
    else rd_a.rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_a.rd_en = 1'b0;
    rd_b.rd_en = 1'b0;
  endtask

  task automatic pulse_clr(input bit sel);
    @(posedge clk);
    #1;
    if (sel) clr_b = 1'b1;
    else clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    rd_a.rd_en = 1'b0;
    rd_b.rd_en = 1'b0;
    wait_clks(3);
    check("reset_valid", rd_a.rd_valid, 0);
    check("reset_count", rd_a.count, 0);
    check("reset_data", rd_a.rd_data, 0);
    check("reset_flags", {pe_a, fe_a, ov_a, bk_a}, 0);
    reset = 1'b1;
    #(2 * BitNs);

    // 0xD2 sent about 1.9% slow
    exp_a.push_back(8'hD2);
    frame8(0, 8'hD2, 1'b1, 652);
    wait_clks(4);
    check("d2_valid", rd_a.rd_valid, 1);
    check("d2_data", rd_a.rd_data, 8'hD2);
    check("d2_count", rd_a.count, 1);
    check("d2_flags", {pe_a, fe_a, ov_a, bk_a}, 0);
    pop_one(0);
    check("d2_popped_valid", rd_a.rd_valid, 0);

    // Even parity: 0x0F needs parity 0, send 1
    exp_b.push_back(8'h0F);
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h0F, 1'b0}, 11, BitNs);
    wait_clks(4);
    check("par_err_set", pe_b, 1);
    check("par_frame_ok", fe_b, 0);
    check("par_count", rd_b.count, 1);
    check("par_data", rd_b.rd_data, 8'h0F);
    pop_one(1);
    pulse_clr(1);
    check("par_err_cleared", pe_b, 0);

    // Framing error then a 10-bit break
    exp_a.push_back(8'h8A);
    frame8(0, 8'h8A, 1'b0, BitNs);
    wait_clks(4);
    check("fe_set", fe_a, 1);
    check("fe_no_break", bk_a, 0);
    check("fe_data", rd_a.rd_data, 8'h8A);
    rx_a = 1'b1;
    #(BitNs);
    exp_a.push_back(8'h00);
    rx_a = 1'b0;
    #(10 * BitNs);
    rx_a = 1'b1;
    wait_clks(4);
    check("break_set", bk_a, 1);
    check("break_fe", fe_a, 1);
    #(2 * BitNs);
    check("break_count", rd_a.count, 2);
    pop_one(0);
    pop_one(0);
    pulse_clr(0);
    check("break_cleared", {fe_a, bk_a}, 0);

    // Overrun: five bytes, no reads
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_a.push_back(8'(i));
      frame8(0, 8'(i), 1'b1, BitNs);
    end
    wait_clks(4);
    check("ovr_count", rd_a.count, 4);
    check("ovr_flag", ov_a, 1);
    for (int i = 0; i < 4; i++) pop_one(0);
    check("ovr_drained", rd_a.rd_valid, 0);
    pulse_clr(0);
    check("ovr_cleared", ov_a, 0);

    // Full FIFO, pop in the push cycle of 0x66
    for (int i = 1; i <= 4; i++) begin
      exp_a.push_back(8'(8'h11 * i));
      frame8(0, 8'(8'h11 * i), 1'b1, BitNs);
    end
    wait_clks(4);
    check("full_count", rd_a.count, 4);
    exp_a.push_back(8'h66);
    n = 0;
    fork
      frame8(0, 8'h66, 1'b1, BitNs);
      begin
        @(posedge clk);
        #1;
        while (!u_dut.push_q && n < 2000) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (!u_dut.push_q) begin
          checks++;
          $display("FAIL push_wait: no push seen after %0d cycles, expected one", n);
        end else begin
          rd_a.rd_en = 1'b1;
          @(posedge clk);
          #1;
          rd_a.rd_en = 1'b0;
        end
      end
    join
    wait_clks(4);
    check("pp_count", rd_a.count, 4);
    check("pp_overrun", ov_a, 0);
    for (int i = 0; i < 4; i++) pop_one(0);
    check("pp_drained", rd_a.count, 0);

    // 3-tick glitch is a false start
    rx_a = 1'b0;
    #120;
    rx_a = 1'b1;
    #(3 * BitNs);
    check("glitch_count", rd_a.count, 0);
    check("glitch_flags", {pe_a, fe_a, ov_a, bk_a}, 0);

    // Reset mid-frame, line held low across release
    send_bits(0, 16'h0000, 5, BitNs);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    #(3 * BitNs);
    rx_a = 1'b1;
    #(3 * BitNs);
    check("rst_count", rd_a.count, 0);
    check("rst_valid", rd_a.rd_valid, 0);
    exp_a.push_back(8'hA5);
    frame8(0, 8'hA5, 1'b1, BitNs);
    wait_clks(4);
    check("a5_count", rd_a.count, 1);
    check("a5_flags", {pe_a, fe_a, ov_a, bk_a}, 0);
    pop_one(0);
    wait_clks(2);
    check("sb_a_empty", exp_a.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
